// File: rtl/gray_step_decoder_if.sv
// Bus between a 2-bit Gray code source and gray_step_decoder.
// master = code source / consumer of position; slave = the decoder.
interface gray_step_decoder_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    logic             in_valid;
    logic [1:0]       code;
    logic             locked;
    logic [CNT_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, code,
        input  locked, pos, dir, step, err, err_cnt
    );

    modport slave (
        input  in_valid, code,
        output locked, pos, dir, step, err, err_cnt
    );
endinterface

// File: rtl/gray_step_decoder.sv
// Classifies 2-bit Gray step transitions into forward/reverse/illegal and tracks position.
// Optional macro GRAY_STEP_DECODER_SYNC_EN adds a two-stage input synchroniser (latency 3).
module gray_step_decoder #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_step_decoder_if.slave bus
);

    typedef enum logic {
        UNLOCKED,
        TRACK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ref_q, ref_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             s_valid;
    logic [1:0]       s_code;

`ifdef GRAY_STEP_DECODER_SYNC_EN
    logic [1:0] valid_sync;
    logic [1:0] code_s1, code_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sync <= 2'b00;
            code_s1    <= 2'b00;
            code_s2    <= 2'b00;
        end else begin
            valid_sync <= {valid_sync[0], bus.in_valid};
            code_s1    <= bus.code;
            code_s2    <= code_s1;
        end
    end

    assign s_valid = valid_sync[1];
    assign s_code  = code_s2;
`else
    assign s_valid = bus.in_valid;
    assign s_code  = bus.code;
`endif

    // Successor of a code in the forward sequence 00->01->11->10->00.
    function automatic logic [1:0] gray_next(input logic [1:0] c);
        case (c)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // NOTE: every variable gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (s_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    ref_d   = s_code;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (s_code == gray_next(ref_q)) begin
                        pos_d  = pos_q + CNT_W'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                        ref_d  = s_code;
                    end else if (gray_next(s_code) == ref_q) begin
                        pos_d  = pos_q - CNT_W'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                        ref_d  = s_code;
                    end else if (s_code == ~ref_q) begin
                        // Illegal jump: resynchronise to the new code, keep position.
                        err_d = 1'b1;
                        ref_d = s_code;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            ref_q     <= 2'b00;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.locked  = (state_q == TRACK);
    assign bus.pos     = pos_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: stimulus queues hand-computed expectations
// tagged with the cycle they become visible; a negedge monitor pops and compares.
module tb_gray_step_decoder;

`ifdef GRAY_STEP_DECODER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_step_decoder_if #(.CNT_W(8), .ERR_W(4)) bus ();

    gray_step_decoder #(.CNT_W(8), .ERR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];

    // Packed view: {locked, pos[7:0], dir, step, err, err_cnt[3:0]}
    function automatic logic [15:0] ev(input int l, input int p, input int d,
                                       input int s, input int e, input int c);
        return {1'(l), 8'(p), 1'(d), 1'(s), 1'(e), 4'(c)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got locked=%0d pos=%0d dir=%0d step=%0d err=%0d err_cnt=%0d, expected locked=%0d pos=%0d dir=%0d step=%0d err=%0d err_cnt=%0d",
                     name, cyc, act[15], act[14:7], act[6], act[5], act[4], act[3:0],
                     exp[15], exp[14:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Called at a negedge; applies inputs for one cycle and queues what must appear.
    task automatic drive(input logic r, input logic v, input logic [1:0] c,
                         input string name, input logic [15:0] exp);
        sb_t e;
        bus.in_valid = v;
        bus.code     = c;
        rst          = r;
        e.name = name;
        e.exp  = exp;
        if (r) begin
            // Reset acts after one edge and discards anything still in flight.
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
            e.cyc = cyc + 1;
        end else begin
            e.cyc = cyc + LAT;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            sb_t e;
            e = sb.pop_front();
            check(e.name, {bus.locked, bus.pos, bus.dir, bus.step, bus.err, bus.err_cnt}, e.exp);
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            sb_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cyc %0d never compared (now %0d)", e.name, e.cyc, cyc);
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.code     = 2'b00;
        @(negedge clk);

        drive(1, 0, 2'b00, "reset_a", ev(0, 0, 0, 0, 0, 0));
        drive(1, 0, 2'b00, "reset_b", ev(0, 0, 0, 0, 0, 0));

        // Lock, then four forward steps.
        drive(0, 1, 2'b00, "lock_00", ev(1, 0, 0, 0, 0, 0));
        drive(0, 1, 2'b01, "fwd_01",  ev(1, 1, 1, 1, 0, 0));
        drive(0, 1, 2'b11, "fwd_11",  ev(1, 2, 1, 1, 0, 0));
        drive(0, 1, 2'b10, "fwd_10",  ev(1, 3, 1, 1, 0, 0));
        drive(0, 1, 2'b00, "fwd_00",  ev(1, 4, 1, 1, 0, 0));

        // Five reverse steps, wrapping 0 -> 255.
        drive(0, 1, 2'b10, "rev_10",      ev(1, 3,   0, 1, 0, 0));
        drive(0, 1, 2'b11, "rev_11",      ev(1, 2,   0, 1, 0, 0));
        drive(0, 1, 2'b01, "rev_01",      ev(1, 1,   0, 1, 0, 0));
        drive(0, 1, 2'b00, "rev_00",      ev(1, 0,   0, 1, 0, 0));
        drive(0, 1, 2'b10, "rev_10_wrap", ev(1, 255, 0, 1, 0, 0));

        // Walk to ref=01, then illegal 01->10, then forward 10->00.
        drive(0, 1, 2'b11, "rev_11_b", ev(1, 254, 0, 1, 0, 0));
        drive(0, 1, 2'b01, "rev_01_b", ev(1, 253, 0, 1, 0, 0));
        drive(0, 1, 2'b10, "err_10",   ev(1, 253, 0, 0, 1, 1));
        drive(0, 1, 2'b00, "fwd_00_b", ev(1, 254, 1, 1, 0, 1));

        // 20 alternating 00<->11 jumps: err every sample, counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, (i % 2 == 0) ? 2'b11 : 2'b00, $sformatf("err_sat_%0d", i),
                  ev(1, 254, 1, 0, 1, (i + 2 > 15) ? 15 : i + 2));
        end

        // Equal codes and valid-low gaps hold everything; wrap 255 -> 0 forward.
        drive(0, 1, 2'b00, "eq_00_a", ev(1, 254, 1, 0, 0, 15));
        drive(0, 1, 2'b00, "eq_00_b", ev(1, 254, 1, 0, 0, 15));
        drive(0, 0, 2'b11, "gap_a",   ev(1, 254, 1, 0, 0, 15));
        drive(0, 0, 2'b11, "gap_b",   ev(1, 254, 1, 0, 0, 15));
        drive(0, 0, 2'b10, "gap_c",   ev(1, 254, 1, 0, 0, 15));
        drive(0, 1, 2'b01, "fwd_01_c", ev(1, 255, 1, 1, 0, 15));
        drive(0, 0, 2'b01, "gap_d",   ev(1, 255, 1, 0, 0, 15));
        drive(0, 0, 2'b00, "gap_e",   ev(1, 255, 1, 0, 0, 15));
        drive(0, 1, 2'b01, "eq_01",   ev(1, 255, 1, 0, 0, 15));
        drive(0, 1, 2'b11, "fwd_11_wrap", ev(1, 0, 1, 1, 0, 15));

        // Mid-stream reset with in_valid high; next sample only relocks.
        drive(0, 1, 2'b10, "fwd_10_pre", ev(1, 1, 1, 1, 0, 15));
        drive(1, 1, 2'b01, "rst_mid",    ev(0, 0, 0, 0, 0, 0));
        drive(0, 1, 2'b11, "relock_11",  ev(1, 0, 0, 0, 0, 0));
        drive(0, 1, 2'b10, "fwd_10_post", ev(1, 1, 1, 1, 0, 0));
        for (int i = 0; i < LAT + 1; i++)
            drive(0, 0, 2'b00, $sformatf("tail_%0d", i), ev(1, 1, 1, 0, 0, 0));

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
